// File: rtl/text_pkg.sv
// -----------------------------------------------------------------------------
// text_pkg
// Shared constants and helpers for the text-mode pixel generator.
//   CHAR_W / CHAR_H   : character cell size in pixels (8 x 16)
//   TEXT_*_DEF        : default text-grid geometry and address widths
//   PIPE_LAT          : input-sample to pixel-out latency in clock cycles
//   FONT_STAGE        : cycle at which the font address is formed
// -----------------------------------------------------------------------------
package text_pkg;

  localparam int CHAR_W          = 8;
  localparam int CHAR_H          = 16;
  localparam int TEXT_COLS_DEF   = 80;
  localparam int TEXT_ROWS_DEF   = 30;
  localparam int TADDR_WIDTH_DEF = 12;
  localparam int FADDR_WIDTH_DEF = 11;
  localparam int CODE_W          = 7;
  localparam int PIPE_LAT        = 5;
  localparam int FONT_STAGE      = 2;
  localparam int FRAME_CNT_W     = 6;

  // Timing strobes travel together down one delay line.
  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } sync_t;

  // row * 80 as (row << 6) + (row << 4); keeps a multiplier out of the
  // address path for the standard 80-column layout.
  function automatic logic [TADDR_WIDTH_DEF-1:0] row_base80(
    input logic [TADDR_WIDTH_DEF-1:0] row
  );
    return (row << 6) + (row << 4);
  endfunction

endpackage

// File: rtl/pipe_delay.sv
// -----------------------------------------------------------------------------
// pipe_delay
// Fixed-length shift register used to realign h/v/de/hs/vs with the
// memory-read stages of the text pipeline.
//   clk_i : pixel clock
//   rst_i : synchronous active-high reset, clears every stage
//   d_i   : WIDTH-bit input sample
//   q_o   : d_i delayed by DEPTH cycles (DEPTH >= 1)
// -----------------------------------------------------------------------------
module pipe_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // NOTE: the stages are reset like any other state (not left as a RAM-style
  // array) so a mid-frame reset cannot push stale timing out afterwards.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments make every stage read the value from
      // before this edge, so the loop order does not matter.
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/text_pixel_gen.sv
// -----------------------------------------------------------------------------
// text_pixel_gen
// Converts a raster position into a monochrome text-mode pixel using an
// external text buffer and font memory, both with registered reads.
// Pipeline (sample taken at cycle n):
//   n+1 text_addr_o   n+2 char_i   n+3 font_addr_o   n+4 font_i   n+5 pixel_o
// Ports:
//   clk_i, rst_i          : pixel clock, synchronous active-high reset
//   h_i, v_i              : pixel column / line
//   de_i, hs_i, vs_i      : timing strobes aligned with h_i/v_i
//   text_addr_o, char_i   : text-buffer address and returned character code
//   font_addr_o, font_i   : font-memory address and returned glyph row
//   pixel_o, de_o, hs_o, vs_o : pixel and timing, all delayed by 5 cycles
// Optional feature (macro TEXT_CURSOR_EN): blinking underline cursor with
//   cursor_en_i, cursor_col_i, cursor_row_i and a vsync-driven frame counter.
// -----------------------------------------------------------------------------
module text_pixel_gen
  import text_pkg::*;
#(
  parameter int TEXT_COLS   = TEXT_COLS_DEF,
  parameter int TEXT_ROWS   = TEXT_ROWS_DEF,
  parameter int TADDR_WIDTH = TADDR_WIDTH_DEF,
  parameter int FADDR_WIDTH = FADDR_WIDTH_DEF
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [9:0]             h_i,
  input  logic [9:0]             v_i,
  input  logic                   de_i,
  input  logic                   hs_i,
  input  logic                   vs_i,
`ifdef TEXT_CURSOR_EN
  input  logic                   cursor_en_i,
  input  logic [6:0]             cursor_col_i,
  input  logic [4:0]             cursor_row_i,
`endif
  output logic [TADDR_WIDTH-1:0] text_addr_o,
  input  logic [7:0]             char_i,
  output logic [FADDR_WIDTH-1:0] font_addr_o,
  input  logic [7:0]             font_i,
  output logic                   pixel_o,
  output logic                   de_o,
  output logic                   hs_o,
  output logic                   vs_o
);

  localparam int HBIT_W = $clog2(CHAR_W);     // pixel-in-cell bits of h
  localparam int GROW_W = $clog2(CHAR_H);     // glyph-row bits of v
  localparam int ROW_W  = $clog2(TEXT_ROWS);  // text-row bits of v

`ifdef TEXT_CURSOR_EN
  // The cursor needs the full cell coordinate at the pixel stage.
  localparam int HD_W = 10;
  localparam int VD_W = 9;
`else
  localparam int HD_W = HBIT_W;
  localparam int VD_W = GROW_W;
`endif

  // ---------------------------------------------------------------------------
  // Delay lines
  // ---------------------------------------------------------------------------
  logic [VD_W-1:0] v_d2;
  logic [HD_W-1:0] h_d4;
  sync_t           ctl_in;
  sync_t           ctl_d4;

  assign ctl_in = '{de: de_i, hs: hs_i, vs: vs_i};

  pipe_delay #(.WIDTH(VD_W), .DEPTH(FONT_STAGE)) u_v_dly (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (v_i[VD_W-1:0]),
    .q_o   (v_d2)
  );

  pipe_delay #(.WIDTH(HD_W), .DEPTH(PIPE_LAT - 1)) u_h_dly (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (h_i[HD_W-1:0]),
    .q_o   (h_d4)
  );

  // The fifth stage of de/hs/vs is the output register below, in step with
  // pixel_o.
  pipe_delay #(.WIDTH($bits(sync_t)), .DEPTH(PIPE_LAT - 1)) u_ctl_dly (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (ctl_in),
    .q_o   (ctl_d4)
  );

  // ---------------------------------------------------------------------------
  // Text-buffer address: row * TEXT_COLS + column
  // ---------------------------------------------------------------------------
  logic [ROW_W-1:0]       row;
  logic [TADDR_WIDTH-1:0] row_base;

  // Blanking lines are addressed too; v_i[8:4] = 31 still fits the width.
  assign row = v_i[GROW_W +: ROW_W];

  if (TEXT_COLS == 80) begin : g_base80
    assign row_base = TADDR_WIDTH'(row_base80(TADDR_WIDTH_DEF'(row)));
  end else begin : g_base_mul
    assign row_base = TADDR_WIDTH'(row * TEXT_COLS);
  end

  // ---------------------------------------------------------------------------
  // Next-state logic and registers
  // ---------------------------------------------------------------------------
  logic [TADDR_WIDTH-1:0] text_addr_q, text_addr_d;
  logic [FADDR_WIDTH-1:0] font_addr_q, font_addr_d;
  logic                   pixel_q, pixel_d;
  logic                   de_q, hs_q, vs_q;
  logic [HBIT_W-1:0]      bit_sel;
  logic                   cursor_hit;

`ifdef TEXT_CURSOR_EN
  logic [VD_W-1:0]        v_d4;
  logic                   vs_prev_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  // Line number continued to the pixel stage for the cell/glyph-row match.
  pipe_delay #(.WIDTH(VD_W), .DEPTH(PIPE_LAT - 1 - FONT_STAGE)) u_v_dly2 (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (v_d2),
    .q_o   (v_d4)
  );
`endif

  always_comb begin
    // NOTE: every combinational output gets a value before any condition,
    // so no latches can be inferred.
    text_addr_d = row_base + TADDR_WIDTH'(h_i[9:3]);
    // Character bit 7 is not part of the font index.
    font_addr_d = FADDR_WIDTH'({char_i[CODE_W-1:0], v_d2[GROW_W-1:0]});
    // Glyph bit 7 is the leftmost pixel of the cell.
    bit_sel     = HBIT_W'(CHAR_W - 1) - h_d4[HBIT_W-1:0];
    cursor_hit  = 1'b0;
`ifdef TEXT_CURSOR_EN
    frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(vs_i & ~vs_prev_q);
    // Underline on glyph rows 14-15, blinking with counter bit 5.
    cursor_hit  = cursor_en_i & frame_cnt_q[FRAME_CNT_W-1] & ctl_d4.de
                & (h_d4[9:3] == cursor_col_i)
                & (v_d4[8:4] == cursor_row_i)
                & (v_d4[3:0] >= 4'd14);
`endif
    pixel_d     = (font_i[bit_sel] & ctl_d4.de) ^ cursor_hit;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      text_addr_q <= '0;
      font_addr_q <= '0;
      pixel_q     <= 1'b0;
      de_q        <= 1'b0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
`ifdef TEXT_CURSOR_EN
      vs_prev_q   <= 1'b0;
      frame_cnt_q <= '0;
`endif
    end else begin
      text_addr_q <= text_addr_d;
      font_addr_q <= font_addr_d;
      pixel_q     <= pixel_d;
      de_q        <= ctl_d4.de;
      hs_q        <= ctl_d4.hs;
      vs_q        <= ctl_d4.vs;
`ifdef TEXT_CURSOR_EN
      vs_prev_q   <= vs_i;
      frame_cnt_q <= frame_cnt_d;
`endif
    end
  end

  assign text_addr_o = text_addr_q;
  assign font_addr_o = font_addr_q;
  assign pixel_o     = pixel_q;
  assign de_o        = de_q;
  assign hs_o        = hs_q;
  assign vs_o        = vs_q;

  // Input bits that the address arithmetic deliberately ignores.
  logic unused_in;
  assign unused_in = ^{char_i[CHAR_W-1], v_i};

endmodule

// File: tb/tb_text_pixel_gen.sv
// -----------------------------------------------------------------------------
// tb_text_pixel_gen
// Directed bench for text_pixel_gen. Character and font data are driven as
// constants per scenario; outputs are sampled 1 time unit after each rising
// edge. Define TEXT_CURSOR_EN to include the cursor scenario.
// -----------------------------------------------------------------------------
module tb_text_pixel_gen;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [9:0]  h_i, v_i;
  logic        de_i, hs_i, vs_i;
  logic [7:0]  char_i, font_i;
  logic [11:0] text_addr_o;
  logic [10:0] font_addr_o;
  logic        pixel_o, de_o, hs_o, vs_o;
`ifdef TEXT_CURSOR_EN
  logic        cursor_en_i;
  logic [6:0]  cursor_col_i;
  logic [4:0]  cursor_row_i;
`endif

  int total = 0;
  int bad   = 0;

  always #20 clk = ~clk;

  text_pixel_gen dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .h_i          (h_i),
    .v_i          (v_i),
    .de_i         (de_i),
    .hs_i         (hs_i),
    .vs_i         (vs_i),
`ifdef TEXT_CURSOR_EN
    .cursor_en_i  (cursor_en_i),
    .cursor_col_i (cursor_col_i),
    .cursor_row_i (cursor_row_i),
`endif
    .text_addr_o  (text_addr_o),
    .char_i       (char_i),
    .font_addr_o  (font_addr_o),
    .font_i       (font_i),
    .pixel_o      (pixel_o),
    .de_o         (de_o),
    .hs_o         (hs_o),
    .vs_o         (vs_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [9:0] h, input logic [9:0] v,
                       input logic de, input logic hs, input logic vs);
    h_i  = h;
    v_i  = v;
    de_i = de;
    hs_i = hs;
    vs_i = vs;
  endtask

  task automatic flush(input int n);
    drive(10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_i  = 1'b1;
    char_i = 8'hFF;
    font_i = 8'hFF;
    drive(10'd639, 10'd479, 1'b1, 1'b1, 1'b1);
    tick();
    tick();
    total++; if (text_addr_o !== 12'd0) begin bad++; $display("FAIL reset_text_addr: got %0d want 0", text_addr_o); end
    total++; if (font_addr_o !== 11'd0) begin bad++; $display("FAIL reset_font_addr: got %0h want 0", font_addr_o); end
    total++; if (pixel_o !== 1'b0) begin bad++; $display("FAIL reset_pixel: got %b want 0", pixel_o); end
    total++; if (de_o !== 1'b0) begin bad++; $display("FAIL reset_de: got %b want 0", de_o); end
    total++; if (hs_o !== 1'b0) begin bad++; $display("FAIL reset_hs: got %b want 0", hs_o); end
    total++; if (vs_o !== 1'b0) begin bad++; $display("FAIL reset_vs: got %b want 0", vs_o); end
    rst_i = 1'b0;
    flush(6);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_text_addr();
    logic [9:0]  h_tab [8] = '{10'd0, 10'd639, 10'd639, 10'd0, 10'd8, 10'd100, 10'd7, 10'd320};
    logic [9:0]  v_tab [8] = '{10'd0, 10'd479, 10'd511, 10'd511, 10'd16, 10'd200, 10'd15, 10'd240};
    logic [11:0] a_tab [8] = '{12'd0, 12'd2399, 12'd2559, 12'd2480, 12'd81, 12'd972, 12'd0, 12'd1240};
    // One new sample per edge: each address appears exactly one cycle later.
    for (int i = 0; i < 8; i++) begin
      drive(h_tab[i], v_tab[i], 1'b1, 1'b0, 1'b0);
      tick();
      total++;
      if (text_addr_o !== a_tab[i]) begin
        bad++;
        $display("FAIL text_addr[%0d] h=%0d v=%0d: got %0d want %0d", i, h_tab[i], v_tab[i], text_addr_o, a_tab[i]);
      end
    end
    flush(6);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_font_addr();
    // Glyph rows streamed through v, row bits 0x1A0 must not leak into the
    // font address; trailing samples return to v=0.
    logic [9:0]  v_tab [7] = '{10'h1A5, 10'h1AA, 10'h1AF, 10'h1A1, 10'h000, 10'h000, 10'h000};
    logic [10:0] f_tab [7] = '{11'h000, 11'h000, 11'h415, 11'h41A, 11'h41F, 11'h411, 11'h410};
    char_i = 8'h41;
    flush(4);
    for (int k = 0; k < 7; k++) begin
      drive(10'd0, v_tab[k], 1'b1, 1'b0, 1'b0);
      tick();
      if (k >= 2) begin
        total++;
        if (font_addr_o !== f_tab[k]) begin
          bad++;
          $display("FAIL font_addr_stream[%0d]: got %h want %h", k, font_addr_o, f_tab[k]);
        end
      end
    end
    // Bit 7 of the character code is ignored.
    char_i = 8'hC1;
    tick();
    tick();
    total++; if (font_addr_o !== 11'h410) begin bad++; $display("FAIL font_addr_c1: got %h want 410", font_addr_o); end
    // A character change shows up on the very next edge.
    char_i = 8'h7F;
    tick();
    total++; if (font_addr_o !== 11'h7F0) begin bad++; $display("FAIL font_addr_char_lat: got %h want 7f0", font_addr_o); end
    char_i = 8'h00;
    flush(6);
  endtask

  // ---------------------------------------------------------------------------
  // exp_seq bit (7-j) is the expected pixel for the j-th pixel of the cell.
  task automatic test_pixel(input logic [7:0] font, input logic de,
                            input logic [7:0] exp_seq, input int id);
    font_i = font;
    flush(6);
    for (int k = 0; k < 12; k++) begin
      if (k < 8) drive(10'd8 + 10'(k), 10'd0, de, 1'b0, 1'b0);
      else       drive(10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
      tick();
      if (k >= 4) begin
        total++;
        if (pixel_o !== exp_seq[7-(k-4)]) begin
          bad++;
          $display("FAIL pixel%0d[%0d]: got %b want %b", id, k - 4, pixel_o, exp_seq[7-(k-4)]);
        end
        total++;
        if (de_o !== de) begin
          bad++;
          $display("FAIL pixel%0d_de[%0d]: got %b want %b", id, k - 4, de_o, de);
        end
      end
    end
    font_i = 8'h00;
    flush(6);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_sync();
    // hs at sample 0, vs at sample 1, de at sample 2; each must emerge five
    // cycles later, i.e. after edge 4, 5 and 6 respectively.
    logic [9:0] hs_exp = 10'b0000010000;
    logic [9:0] vs_exp = 10'b0000100000;
    logic [9:0] de_exp = 10'b0001000000;
    font_i = 8'h00;
    flush(6);
    for (int k = 0; k < 10; k++) begin
      drive(10'd0, 10'd0, k == 2, k == 0, k == 1);
      tick();
      total++; if (hs_o !== hs_exp[k]) begin bad++; $display("FAIL sync_hs[%0d]: got %b want %b", k, hs_o, hs_exp[k]); end
      total++; if (vs_o !== vs_exp[k]) begin bad++; $display("FAIL sync_vs[%0d]: got %b want %b", k, vs_o, vs_exp[k]); end
      total++; if (de_o !== de_exp[k]) begin bad++; $display("FAIL sync_de[%0d]: got %b want %b", k, de_o, de_exp[k]); end
    end
    flush(6);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_flush();
    font_i = 8'hFF;
    for (int k = 0; k < 7; k++) begin
      drive(10'd600 + 10'(k), 10'd479, 1'b1, 1'b1, 1'b1);
      tick();
    end
    total++; if (pixel_o !== 1'b1) begin bad++; $display("FAIL flush_prefill_pixel: got %b want 1", pixel_o); end
    // Mid-line reset; inputs keep a non-zero address but carry de=0.
    rst_i = 1'b1;
    drive(10'd639, 10'd479, 1'b0, 1'b0, 1'b0);
    tick();
    total++; if (text_addr_o !== 12'd0) begin bad++; $display("FAIL flush_text_addr: got %0d want 0", text_addr_o); end
    total++; if (font_addr_o !== 11'd0) begin bad++; $display("FAIL flush_font_addr: got %h want 0", font_addr_o); end
    total++; if (pixel_o !== 1'b0) begin bad++; $display("FAIL flush_pixel: got %b want 0", pixel_o); end
    total++; if (de_o !== 1'b0) begin bad++; $display("FAIL flush_de: got %b want 0", de_o); end
    total++; if (hs_o !== 1'b0) begin bad++; $display("FAIL flush_hs: got %b want 0", hs_o); end
    rst_i = 1'b0;
    drive(10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
    // Post-reset samples all carry de/hs/vs=0: any 1 would be stale data.
    for (int k = 0; k < 6; k++) begin
      tick();
      total++; if (pixel_o !== 1'b0) begin bad++; $display("FAIL flush_after_pixel[%0d]: got %b want 0", k, pixel_o); end
      total++; if (de_o !== 1'b0) begin bad++; $display("FAIL flush_after_de[%0d]: got %b want 0", k, de_o); end
      total++; if (hs_o !== 1'b0) begin bad++; $display("FAIL flush_after_hs[%0d]: got %b want 0", k, hs_o); end
    end
    font_i = 8'h00;
    flush(6);
  endtask

`ifdef TEXT_CURSOR_EN
  // ---------------------------------------------------------------------------
  task automatic vs_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      drive(10'd0, 10'd0, 1'b0, 1'b0, 1'b1);
      tick();
      drive(10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
      tick();
    end
  endtask

  // h = 22..33 spans cells 2,3,4; only column 3 (h 24..31) is under the cursor.
  task automatic cursor_pass(input logic [9:0] v, input logic [11:0] exp_seq,
                             input int id);
    flush(6);
    for (int k = 0; k < 16; k++) begin
      if (k < 12) drive(10'd22 + 10'(k), v, 1'b1, 1'b0, 1'b0);
      else        drive(10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
      tick();
      if (k >= 4) begin
        total++;
        if (pixel_o !== exp_seq[11-(k-4)]) begin
          bad++;
          $display("FAIL cursor%0d[%0d]: got %b want %b", id, k - 4, pixel_o, exp_seq[11-(k-4)]);
        end
      end
    end
  endtask

  task automatic test_cursor();
    font_i       = 8'h00;
    cursor_col_i = 7'd3;
    cursor_row_i = 5'd2;
    cursor_en_i  = 1'b1;
    // Counter starts at 0 after the reset in test_reset_flush.
    vs_pulses(32);
    cursor_pass(10'd47, 12'b001111111100, 0);  // row 2, glyph row 15
    cursor_pass(10'd46, 12'b001111111100, 1);  // glyph row 14
    cursor_pass(10'd45, 12'b000000000000, 2);  // glyph row 13: no underline
    cursor_pass(10'd63, 12'b000000000000, 3);  // row 3: wrong row
    vs_pulses(32);                              // counter wraps to 0
    cursor_pass(10'd47, 12'b000000000000, 4);
    cursor_en_i = 1'b0;
    flush(6);
  endtask
`endif

  // ---------------------------------------------------------------------------
  initial begin
`ifdef TEXT_CURSOR_EN
    cursor_en_i  = 1'b0;
    cursor_col_i = 7'd0;
    cursor_row_i = 5'd0;
`endif
    rst_i  = 1'b1;
    char_i = 8'h00;
    font_i = 8'h00;
    drive(10'd0, 10'd0, 1'b0, 1'b0, 1'b0);
    test_reset();
    test_text_addr();
    test_font_addr();
    test_pixel(8'h81, 1'b1, 8'h81, 0);
    test_pixel(8'h81, 1'b0, 8'h00, 1);
    test_pixel(8'hF0, 1'b1, 8'hF0, 2);
    test_sync();
    test_reset_flush();
`ifdef TEXT_CURSOR_EN
    test_cursor();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
